// File: rtl/adc_pkg.sv
// Shared types for the ADC sample path.
//   ADC_WIDTH    : LTC2315 sample width (12-bit straight binary)
//   adc_sample_t : one ADC sample
//   avg_state_t  : block averager control state
package adc_pkg;

  localparam int ADC_WIDTH = 12;

  typedef logic [ADC_WIDTH-1:0] adc_sample_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } avg_state_t;

endpackage

// File: rtl/adc_minmax.sv
// Running min/max tracker for one block of samples.
// Ports:
//   i_sck      clock
//   i_rst      synchronous active-high reset
//   i_clr      re-initialise tracker (min = all ones, max = 0); wins over i_en
//   i_en       sample accepted this cycle
//   i_first    sample is the first of its block: load it into both min and max
//   i_sample   sample value
//   o_min_nxt  min including the current sample (combinational)
//   o_max_nxt  max including the current sample (combinational)
module adc_minmax
  import adc_pkg::*;
#(
  parameter int WIDTH = ADC_WIDTH
) (
  input  logic             i_sck,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_first,
  input  logic [WIDTH-1:0] i_sample,
  output logic [WIDTH-1:0] o_min_nxt,
  output logic [WIDTH-1:0] o_max_nxt
);

  logic [WIDTH-1:0] r_min;
  logic [WIDTH-1:0] r_max;

  always_comb begin
    o_min_nxt = r_min;
    o_max_nxt = r_max;
    if (i_first) begin
      o_min_nxt = i_sample;
      o_max_nxt = i_sample;
    end else begin
      if (i_sample < r_min) o_min_nxt = i_sample;
      if (i_sample > r_max) o_max_nxt = i_sample;
    end
  end

  always_ff @(posedge i_sck) begin
    if (i_rst || i_clr) begin
      r_min <= '1;
      r_max <= '0;
    end else if (i_en) begin
      r_min <= o_min_nxt;
      r_max <= o_max_nxt;
    end
  end

endmodule

// File: rtl/adc_block_averager.sv
// Groups 2**LOG2_N accepted ADC samples into a block and reports the block
// mean and peak-to-peak amplitude on a ready/valid stream.
// Optional feature macro: ADC_AVG_ERR_SKIP_EN
//   defined   : samples flagged with sample_error_i are skipped (not accepted)
//   undefined : flagged samples are accumulated like any other
//   Either way blk_err_o marks a block that saw at least one flagged sample.
// Ports:
//   sck, rst        clock, synchronous active-high reset
//   en_i            1 = accumulate, 0 = drop the partial block
//   sample_i        ADC sample, qualified by sample_valid_i
//   sample_error_i  start-bit error flag of the sample
//   mean_o, ptp_o   block mean (truncating) and max - min
//   blk_err_o       block contained a flagged sample
//   overrun_o       a later block was discarded while this result was held
//   out_valid_o / out_ready_i   result handshake
//
// state | meaning
// IDLE  | not accumulating; block state held at its initial values
// ACCUM | accepting samples into the current block
module adc_block_averager
  import adc_pkg::*;
#(
  parameter int LOG2_N = 4,
  parameter int WIDTH  = ADC_WIDTH
) (
  input  logic             sck,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] sample_i,
  input  logic             sample_valid_i,
  input  logic             sample_error_i,
  output logic [WIDTH-1:0] mean_o,
  output logic [WIDTH-1:0] ptp_o,
  output logic             blk_err_o,
  output logic             overrun_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  localparam int ACC_W = WIDTH + LOG2_N;

  avg_state_t        r_state;
  logic [ACC_W-1:0]  r_acc;
  logic [LOG2_N-1:0] r_cnt;
  logic              r_err;

  logic              w_active;
  logic              w_flagged;
  logic              w_accept;
  logic              w_blk_end;
  logic              w_blk_clr;
  logic              w_first;
  logic              w_err_nxt;
  logic              w_handshake;
  logic [ACC_W-1:0]  w_sum;
  logic [WIDTH-1:0]  w_min_nxt;
  logic [WIDTH-1:0]  w_max_nxt;

  assign w_active  = (r_state == ACCUM) && en_i;
  assign w_flagged = w_active && sample_valid_i && sample_error_i;

`ifdef ADC_AVG_ERR_SKIP_EN
  assign w_accept = w_active && sample_valid_i && !sample_error_i;
`else
  assign w_accept = w_active && sample_valid_i;
`endif

  // A flagged sample marks the block whether it was skipped or accumulated.
  assign w_err_nxt   = r_err | w_flagged;
  assign w_blk_end   = w_accept && (&r_cnt);
  assign w_blk_clr   = !w_active || w_blk_end;
  assign w_first     = (r_cnt == '0);
  assign w_sum       = r_acc + ACC_W'(sample_i);
  assign w_handshake = out_valid_o && out_ready_i;

  always_ff @(posedge sck) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      unique case (r_state)
        IDLE:    if (en_i)  r_state <= ACCUM;
        ACCUM:   if (!en_i) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Leaving ACCUM (or dropping en_i) discards the partial block, so re-entry
  // always begins from a clean accumulator.
  always_ff @(posedge sck) begin
    if (rst || w_blk_clr) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_err_nxt;
      if (w_accept) begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  adc_minmax #(
    .WIDTH(WIDTH)
  ) u_minmax (
    .i_sck     (sck),
    .i_rst     (rst),
    .i_clr     (w_blk_clr),
    .i_en      (w_accept),
    .i_first   (w_first),
    .i_sample  (sample_i),
    .o_min_nxt (w_min_nxt),
    .o_max_nxt (w_max_nxt)
  );

  // Result is built from the next-state sum/min/max so the sample closing the
  // block is included. A held, untaken result wins over a newer block.
  always_ff @(posedge sck) begin
    if (rst) begin
      mean_o      <= '0;
      ptp_o       <= '0;
      blk_err_o   <= 1'b0;
      overrun_o   <= 1'b0;
      out_valid_o <= 1'b0;
    end else if (w_blk_end) begin
      if (out_valid_o && !out_ready_i) begin
        overrun_o <= 1'b1;
      end else begin
        mean_o      <= w_sum[LOG2_N +: WIDTH];
        ptp_o       <= w_max_nxt - w_min_nxt;
        blk_err_o   <= w_err_nxt;
        overrun_o   <= 1'b0;
        out_valid_o <= 1'b1;
      end
    end else if (w_handshake) begin
      out_valid_o <= 1'b0;
      overrun_o   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_block_averager.sv
module tb_adc_block_averager;

`ifdef ADC_AVG_ERR_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        en = 1'b0, vld = 1'b0, serr = 1'b0, rdy = 1'b0;
  logic [11:0] smp = '0;
  logic [11:0] mean, ptp;
  logic        berr, ovr, ovld;

  logic        en8 = 1'b0, vld8 = 1'b0, serr8 = 1'b0, rdy8 = 1'b0;
  logic [11:0] smp8 = '0;
  logic [11:0] mean8, ptp8;
  logic        berr8, ovr8, ovld8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  adc_block_averager #(.LOG2_N(2), .WIDTH(12)) dut (
    .sck(clk), .rst(rst), .en_i(en), .sample_i(smp), .sample_valid_i(vld),
    .sample_error_i(serr), .mean_o(mean), .ptp_o(ptp), .blk_err_o(berr),
    .overrun_o(ovr), .out_valid_o(ovld), .out_ready_i(rdy)
  );

  adc_block_averager #(.LOG2_N(8), .WIDTH(12)) dut8 (
    .sck(clk), .rst(rst), .en_i(en8), .sample_i(smp8), .sample_valid_i(vld8),
    .sample_error_i(serr8), .mean_o(mean8), .ptp_o(ptp8), .blk_err_o(berr8),
    .overrun_o(ovr8), .out_valid_o(ovld8), .out_ready_i(rdy8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [11:0] s, input logic e);
    smp = s; serr = e; vld = 1'b1;
    tick();
    vld = 1'b0; serr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; rdy = 1'b0;
    tick(); tick();
    rst = 1'b0;
    n_tests++; if (ovld !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", ovld); end
    n_tests++; if (mean !== 12'd0) begin n_fail++; $display("FAIL reset_mean got=%0d exp=0", mean); end
    n_tests++; if (ptp !== 12'd0) begin n_fail++; $display("FAIL reset_ptp got=%0d exp=0", ptp); end
    n_tests++; if (berr !== 1'b0) begin n_fail++; $display("FAIL reset_blkerr got=%b exp=0", berr); end
    n_tests++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got=%b exp=0", ovr); end
  endtask

  task automatic test_basic();
    rdy = 1'b1; en = 1'b1;
    tick();
    put(100, 0); put(200, 0); put(300, 0);
    n_tests++; if (ovld !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid got=%b exp=0", ovld); end
    put(400, 0);
    n_tests++; if (ovld !== 1'b1) begin n_fail++; $display("FAIL basic_valid got=%b exp=1", ovld); end
    n_tests++; if (mean !== 12'd250) begin n_fail++; $display("FAIL basic_mean got=%0d exp=250", mean); end
    n_tests++; if (ptp !== 12'd300) begin n_fail++; $display("FAIL basic_ptp got=%0d exp=300", ptp); end
    n_tests++; if (berr !== 1'b0) begin n_fail++; $display("FAIL basic_blkerr got=%b exp=0", berr); end
    tick();
    n_tests++; if (ovld !== 1'b0) begin n_fail++; $display("FAIL basic_drain got=%b exp=0", ovld); end
  endtask

  task automatic test_overrun();
    rdy = 1'b0;
    repeat (4) put(8, 0);
    n_tests++; if (ovld !== 1'b1 || mean !== 12'd8) begin n_fail++; $display("FAIL ovr_first got valid=%b mean=%0d exp valid=1 mean=8", ovld, mean); end
    repeat (4) put(4, 0);
    n_tests++; if (mean !== 12'd8) begin n_fail++; $display("FAIL ovr_held_mean got=%0d exp=8", mean); end
    n_tests++; if (ovr !== 1'b1) begin n_fail++; $display("FAIL ovr_flag got=%b exp=1", ovr); end
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    n_tests++; if (ovld !== 1'b0 || ovr !== 1'b0) begin n_fail++; $display("FAIL ovr_drain got valid=%b ovr=%b exp 0 0", ovld, ovr); end
  endtask

  task automatic test_back_to_back();
    rdy = 1'b0;
    repeat (4) put(1, 0);
    put(0, 0); put(4095, 0); put(0, 0);
    rdy = 1'b1;
    put(4095, 0);
    n_tests++; if (ovld !== 1'b1) begin n_fail++; $display("FAIL b2b_valid got=%b exp=1", ovld); end
    n_tests++; if (mean !== 12'd2047) begin n_fail++; $display("FAIL b2b_mean got=%0d exp=2047", mean); end
    n_tests++; if (ptp !== 12'd4095) begin n_fail++; $display("FAIL b2b_ptp got=%0d exp=4095", ptp); end
    n_tests++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun got=%b exp=0", ovr); end
    tick();
  endtask

  task automatic test_abort();
    rdy = 1'b1;
    put(7, 0); put(4000, 0);
    en = 1'b0; tick();
    en = 1'b1; tick();
    repeat (4) put(10, 0);
    n_tests++; if (ovld !== 1'b1 || mean !== 12'd10 || ptp !== 12'd0) begin n_fail++; $display("FAIL abort got valid=%b mean=%0d ptp=%0d exp 1 10 0", ovld, mean, ptp); end
    tick();
  endtask

  task automatic test_error();
    logic [11:0] vals [5];
    int          chk;
    vals[0] = 50; vals[1] = 999; vals[2] = 50; vals[3] = 50; vals[4] = 50;
    chk = SKIP ? 4 : 3;
    rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      put(vals[i], (i == 1));
      if (i == chk) begin
        n_tests++; if (ovld !== 1'b1) begin n_fail++; $display("FAIL err_valid got=%b exp=1", ovld); end
        n_tests++; if (berr !== 1'b1) begin n_fail++; $display("FAIL err_blkerr got=%b exp=1", berr); end
        if (SKIP) begin
          n_tests++; if (mean !== 12'd50 || ptp !== 12'd0) begin n_fail++; $display("FAIL err_skip got mean=%0d ptp=%0d exp 50 0", mean, ptp); end
        end else begin
          n_tests++; if (mean !== 12'd287 || ptp !== 12'd949) begin n_fail++; $display("FAIL err_acc got mean=%0d ptp=%0d exp 287 949", mean, ptp); end
        end
      end
    end
    en = 1'b0; tick(); tick();
  endtask

  task automatic test_random();
    logic [11:0] q[$];
    bit          m_act, m_valid, m_ovr, m_err, m_berr, blk_end, acc_ok, in_blk;
    int          m_mean, m_ptp, sum, mn, mx;
    rst = 1'b1; en = 1'b0; tick(); rst = 1'b0;
    m_act = 0; m_valid = 0; m_ovr = 0; m_err = 0; m_berr = 0; m_mean = 0; m_ptp = 0;
    for (int c = 0; c < 600; c++) begin
      en   = ($urandom_range(0, 19) != 0);
      vld  = ($urandom_range(0, 9) < 7);
      serr = ($urandom_range(0, 9) == 0);
      smp  = 12'($urandom_range(0, 4095));
      rdy  = $urandom_range(0, 1);
      blk_end = 0;
      in_blk  = m_act && en;
      acc_ok  = in_blk && vld && !(SKIP && serr);
      if (!in_blk) begin
        q.delete(); m_err = 0;
      end else begin
        if (vld && serr) m_err = 1;
        if (acc_ok) q.push_back(smp);
        if (q.size() == 4) begin
          sum = 0; mn = 4095; mx = 0;
          foreach (q[k]) begin
            sum += q[k];
            if (q[k] < mn) mn = q[k];
            if (q[k] > mx) mx = q[k];
          end
          blk_end = 1;
          if (m_valid && !rdy) begin
            m_ovr = 1;
          end else begin
            m_mean = sum / 4; m_ptp = mx - mn; m_berr = m_err; m_ovr = 0; m_valid = 1;
          end
          q.delete(); m_err = 0;
        end
      end
      if (!blk_end && m_valid && rdy) begin m_valid = 0; m_ovr = 0; end
      m_act = en;
      tick();
      n_tests++;
      if (ovld !== m_valid || ovr !== m_ovr ||
          (m_valid && (mean !== 12'(m_mean) || ptp !== 12'(m_ptp) || berr !== m_berr))) begin
        n_fail++;
        $display("FAIL rand_cycle%0d got v=%b o=%b m=%0d p=%0d e=%b exp v=%b o=%b m=%0d p=%0d e=%b",
                 c, ovld, ovr, mean, ptp, berr, m_valid, m_ovr, m_mean, m_ptp, m_berr);
      end
    end
    vld = 1'b0; serr = 1'b0; en = 1'b0; rdy = 1'b0;
  endtask

  task automatic test_long_block();
    rdy8 = 1'b1; en8 = 1'b1; smp8 = 12'd4095;
    tick();
    vld8 = 1'b1;
    repeat (256) tick();
    vld8 = 1'b0;
    n_tests++; if (ovld8 !== 1'b1 || mean8 !== 12'd4095 || ptp8 !== 12'd0) begin n_fail++; $display("FAIL long_block got valid=%b mean=%0d ptp=%0d exp 1 4095 0", ovld8, mean8, ptp8); end
    tick();
    rdy8 = 1'b0;
    vld8 = 1'b1;
    repeat (266) tick();
    vld8 = 1'b0;
    n_tests++; if (ovld8 !== 1'b1) begin n_fail++; $display("FAIL long_held got=%b exp=1", ovld8); end
    rst = 1'b1; tick(); rst = 1'b0;
    n_tests++; if (ovld8 !== 1'b0 || mean8 !== 12'd0 || ptp8 !== 12'd0 || berr8 !== 1'b0 || ovr8 !== 1'b0) begin
      n_fail++; $display("FAIL long_rst got v=%b m=%0d p=%0d e=%b o=%b exp all 0", ovld8, mean8, ptp8, berr8, ovr8);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_back_to_back();
    test_abort();
    test_error();
    test_random();
    test_long_block();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
